// File: rtl/rv_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit.
// funct3 sizes, fault codes and LSU state encoding.
package rv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_MISAL   = 2'b01;
    localparam logic [1:0] FLT_ILLEGAL = 2'b10;
    localparam logic [1:0] FLT_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BUSY  = 2'b01,
        FAULT = 2'b10,
        DONE  = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane steering, load extension and fault classification.
// Purely combinational; load side uses the funct3/offset latched at issue.
module lsu_align
    import rv_mem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic        i_read,
    input  logic        i_write,
    input  logic [31:0] i_store_data,
    input  logic [2:0]  i_ld_funct3,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ld_data,
    output logic [1:0]  o_fault
);

    logic        w_illegal;
    logic        w_misal;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_be    = 4'b0000;
        o_wdata = i_store_data;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be    = 4'b0001 << i_off;
                o_wdata = {4{i_store_data[7:0]}};
            end
            F3_H, F3_HU: begin
                o_be    = i_off[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_store_data[15:0]}};
            end
            F3_W: o_be = 4'b1111;
            default: o_be = 4'b0000;
        endcase
    end

    always_comb begin
        w_illegal = (i_read & i_write)
                  | (i_funct3 == 3'b011)
                  | (i_funct3 == 3'b110)
                  | (i_funct3 == 3'b111)
                  | (i_write & ((i_funct3 == F3_BU) | (i_funct3 == F3_HU)));
        w_misal   = (((i_funct3 == F3_H) | (i_funct3 == F3_HU)) & i_off[0])
                  | ((i_funct3 == F3_W) & (i_off != 2'b00));
        o_fault   = FLT_NONE;
        priority case (1'b1)
            w_illegal: o_fault = FLT_ILLEGAL;
            w_misal:   o_fault = FLT_MISAL;
            default:   o_fault = FLT_NONE;
        endcase
    end

    always_comb begin
        w_byte = 8'h00;
        case (i_ld_off)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = i_ld_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    always_comb begin
        o_ld_data = 32'h0;
        case (i_ld_funct3)
            F3_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            F3_BU: o_ld_data = {24'h0, w_byte};
            F3_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            F3_HU: o_ld_data = {16'h0, w_half};
            F3_W:  o_ld_data = i_rdata;
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: req/ack bus FSM with timeout and stall.
// Bus outputs are registered at issue and held stable until ack/abort.
module mem_lsu
    import rv_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_valid,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_load_data,
    output logic [1:0]  o_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [3:0]  o_bus_be,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_ack,
    input  logic [31:0] i_bus_rdata
);

    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic [15:0] r_wait;
    logic [2:0]  r_ld_f3;
    logic [1:0]  r_ld_off;
    logic        r_is_load;
    logic [1:0]  r_pend_fault;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [3:0]  r_bus_be;
    logic [31:0] r_bus_wdata;
    logic        r_done;
    logic [31:0] r_load_data;
    logic [1:0]  r_fault;

    logic        w_request;
    logic        w_ack;
    logic        w_timeout;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_ld_data;
    logic [1:0]  w_fault;

    lsu_align u_align (
        .i_funct3     (i_funct3),
        .i_off        (i_addr[1:0]),
        .i_read       (i_mem_read),
        .i_write      (i_mem_write),
        .i_store_data (i_store_data),
        .i_ld_funct3  (r_ld_f3),
        .i_ld_off     (r_ld_off),
        .i_rdata      (i_bus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_ld_data    (w_ld_data),
        .o_fault      (w_fault)
    );

    assign w_request = i_valid & (i_mem_read | i_mem_write);
    assign w_ack     = r_bus_req & i_bus_ack;
    assign w_timeout = (({1'b0, r_wait} + 17'd1) == 17'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_request)
                    w_next = (w_fault != FLT_NONE) ? FAULT : BUSY;
            end
            BUSY: begin
                if (w_ack || w_timeout) w_next = DONE;
            end
            FAULT:   w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Ack is checked before timeout so a last-cycle ack still succeeds.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait       <= 16'd0;
            r_ld_f3      <= 3'd0;
            r_ld_off     <= 2'd0;
            r_is_load    <= 1'b0;
            r_pend_fault <= FLT_NONE;
            r_bus_req    <= 1'b0;
            r_bus_we     <= 1'b0;
            r_bus_addr   <= 32'h0;
            r_bus_be     <= 4'h0;
            r_bus_wdata  <= 32'h0;
            r_done       <= 1'b0;
            r_load_data  <= 32'h0;
            r_fault      <= FLT_NONE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pend_fault <= w_fault;
                    if (w_request && (w_fault == FLT_NONE)) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= i_mem_write;
                        r_bus_addr  <= {i_addr[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_wait      <= 16'd0;
                        r_ld_f3     <= i_funct3;
                        r_ld_off    <= i_addr[1:0];
                        r_is_load   <= ~i_mem_write;
                    end
                end
                BUSY: begin
                    if (w_ack) begin
                        r_bus_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_fault     <= FLT_NONE;
                        r_load_data <= r_is_load ? w_ld_data : 32'h0;
                    end else if (w_timeout) begin
                        r_bus_req   <= 1'b0;
                        r_done      <= 1'b1;
                        r_fault     <= FLT_TIMEOUT;
                        r_load_data <= 32'h0;
                    end else begin
                        r_wait <= r_wait + 16'd1;
                    end
                end
                FAULT: begin
                    r_done      <= 1'b1;
                    r_fault     <= r_pend_fault;
                    r_load_data <= 32'h0;
                end
                DONE: begin
                    r_done      <= 1'b0;
                    r_fault     <= FLT_NONE;
                    r_load_data <= 32'h0;
                end
                default: r_done <= 1'b0;
            endcase
        end
    end

    assign o_stall = ~reset & (((r_state == IDLE) & w_request)
                             | (r_state == BUSY)
                             | (r_state == FAULT));

    assign o_done      = r_done;
    assign o_load_data = r_load_data;
    assign o_fault     = r_fault;
    assign o_bus_req   = r_bus_req;
    assign o_bus_we    = r_bus_we;
    assign o_bus_addr  = r_bus_addr;
    assign o_bus_be    = r_bus_be;
    assign o_bus_wdata = r_bus_wdata;

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store unit for the MEM stage of the 5-stage RISC-V pipeline. It accepts the memory operation held in the EX/MEM register and runs a req/ack handshake with a data memory of variable latency. Byte lanes are steered and loaded values are extended to 32 bits. While an access is in flight it asserts `stall`, which freezes every pipeline register up to and including MEM/WB.

## Interface
- `TIMEOUT`, default 255: maximum cycles `bus_req` is held without `bus_ack` before the access is aborted (1..65535).
- `clk` in 1: clock, rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `valid` in 1: EX/MEM slot holds a live instruction.
- `mem_read` in 1: the instruction is a load.
- `mem_write` in 1: the instruction is a store.
- `funct3` in 3: access size and extension (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `addr` in 32: byte address from the ALU.
- `store_data` in 32: rs2 value, unaligned to lanes.
- `stall` out 1: hold the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers (their `write` = !stall).
- `done` out 1: one-cycle pulse; `load_data`/`fault` valid this cycle.
- `load_data` out 32: extended load result; 0 for stores and faults.
- `fault` out 2: 00 none, 01 misaligned, 10 illegal (bad funct3, or read and write both set), 11 bus timeout.
- `bus_req` out 1: access request, held until ack.
- `bus_we` out 1: 1 = write.
- `bus_addr` out 32: word address, `addr & ~3`.
- `bus_be` out 4: byte enables.
- `bus_wdata` out 32: lane-replicated store data.
- `bus_ack` in 1: slave completes the access; sampled only while `bus_req` = 1.
- `bus_rdata` in 32: read word, valid with `bus_ack`.

## Operation
- A transaction is requested when `valid & (mem_read | mem_write)` holds while in IDLE.
- **FSM states:**
  - IDLE
    - No request → stay in IDLE.
    - Request with a fault check failing → FAULT.
    - Request, legal and aligned → BUSY. The bus outputs are registered at this edge.
  - BUSY
    - `bus_req` = 1 and the bus outputs are stable.
    - `bus_ack` → DONE, `bus_rdata` captured.
    - Wait counter reaches `TIMEOUT` → DONE with fault 11. `bus_req` drops at that same edge.
  - FAULT → DONE with `fault` set. No bus access occurs.
  - DONE → IDLE unconditionally. `done` = 1 and `stall` = 0 in this state, so MEM/WB captures the result and EX/MEM advances at the same edge.
- **Fault checks:**
  - 10 (illegal) when `mem_read & mem_write`, funct3 is 011, 110 or 111, or a store uses 100 or 101.
  - 01 (misaligned) when H/HU has `addr[0]` = 1, or W has `addr[1:0]` ≠ 0.
  - Illegal has priority over misaligned.
- **Store lanes:**
  - SB: `bus_be` = 1 << `addr[1:0]`, wdata = {4{sd[7:0]}}.
  - SH: `bus_be` = 0011 or 1100 by `addr[1]`, wdata = {2{sd[15:0]}}.
  - SW: `bus_be` = 1111, wdata = sd.
- **Load lanes:** `bus_be` follows the same rule as stores. Select the byte or halfword by `addr[1:0]`. LB and LH sign-extend; LBU and LHU zero-extend.
- `stall` = !reset & ((IDLE & request) | BUSY | FAULT). This is combinational from state and inputs.

## Timing
- **Reset values:** state IDLE, `bus_req`/`bus_we` 0, `bus_addr`/`bus_wdata`/`load_data` 0, `bus_be` 0, `done` 0, `fault` 00, wait counter 0. `stall` = 0 while reset is high.
- **Legal access, `bus_ack` k cycles after `bus_req` rises (k ≥ 1):**
  - Request at cycle T; `bus_req` high from T+1; DONE at T+1+k; `stall` high for cycles T..T+k.
  - The minimum is k = 1, i.e. 3 cycles per memory instruction.
- **Faulting access:** request at T, FAULT at T+1, DONE at T+2. `stall` is high for T and T+1.
- `bus_ack` while `bus_req` = 0 is ignored.
- `bus_ack` arriving in the same cycle the counter reaches `TIMEOUT` counts as ack; the ack wins.
- Back-to-back memory instructions: the next request is seen in the IDLE cycle after DONE. There is no bubble beyond that cycle.
- Non-memory instructions in IDLE: `stall` = 0 and `done` = 0, with zero added latency.
- **Reset mid-access:** return to IDLE at the next edge with `bus_req` = 0. The slave must tolerate an abandoned request.

## Structure
- **Package `rv_mem_pkg`:** the funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), the fault codes, and the state enum (IDLE, BUSY, FAULT, DONE).
- **Sub-module `lsu_align`:** combinational. It computes `bus_be`, store lane replication, load lane extract/extend and the fault classification from `funct3` and `addr[1:0]`. `mem_lsu` holds only the FSM, the timeout counter and the output registers.

## Test plan
- **LW/SW round trip:** SW sd=0xDEADBEEF to addr 0x100, then LW from 0x100. Ack at k=1 → `bus_be` 1111, wdata 0xDEADBEEF; `load_data` = 0xDEADBEEF; `stall` high for 2 cycles per access.
- **Byte/half extension:** `bus_rdata` = 0x80FF7F01.
  - LB @0x103 → 0xFFFFFF80; LBU @0x103 → 0x00000080.
  - LH @0x102 → 0xFFFF80FF; LHU @0x100 → 0x00007F01.
  - SB @0x101 with sd=0xAB → `bus_be` 0010, wdata 0xABABABAB.
- **Misaligned and illegal:**
  - LW @0x102 → no `bus_req`, `fault` 01, `load_data` 0, `done` 2 cycles after request.
  - funct3 = 011 → `fault` 10.
- **Wait states and timeout:**
  - Ack at k=5 → `stall` high 6 cycles.
  - With `TIMEOUT` = 4 and no ack → `bus_req` high 4 cycles, then `fault` 11.
  - Ack on the 4th cycle → `fault` 00.
- **Reset during BUSY:** assert `reset` at k=2 → next cycle `bus_req` = 0, `stall` = 0, all outputs at reset values. A later LW completes normally.
